// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } tx_queue_state_t;

    localparam int LAUNCH_TIMEOUT = 4;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tx_queue_mem.sv
// tx_queue_mem: circular word buffer with registered occupancy and full/empty flags
module tx_queue_mem
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [DATA_BITS-1:0]             wr_data,
    output logic [DATA_BITS-1:0]             head,
    output logic                             empty,
    output logic                             full,
    output logic [occ_width(FIFO_DEPTH)-1:0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = occ_width(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_next;

    assign head = mem[rd_ptr];

    // next occupancy; a simultaneous push and pop leaves it unchanged
    always_comb count_next = count + CW'(push) - CW'(pop);

    // storage needs no reset: entries are only read once a push has filled them
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            empty <= count_next == '0;
            full  <= count_next == CW'(FIFO_DEPTH);
        end

endmodule

// File: rtl/tx_queue.sv
// tx_queue: host-to-transmitter word queue with a CTS-gated launch handshake
module tx_queue
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic [DATA_BITS-1:0]             Wr_Data,
    input  logic                             Wr_En,
    input  logic                             CTS,
    input  logic                             Tx_Busy,
    input  logic                             Overflow_Clr,
    output logic [DATA_BITS-1:0]             Tx_Data,
    output logic                             Transmit_Start,
    output logic                             Queue_Empty,
    output logic                             Queue_Full,
    output logic                             Queue_Overflow,
    output logic [occ_width(FIFO_DEPTH)-1:0] Count
);
    localparam int TW = $clog2(LAUNCH_TIMEOUT);

    tx_queue_state_t      state;
    logic [TW-1:0]        tmr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    // the head word leaves only once the transmitter has acknowledged it
    assign pop  = (state == WAIT_BUSY) && Tx_Busy;
    assign push = Wr_En && (!Queue_Full || pop);

    tx_queue_mem #(
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_mem (
        .clk    (Clk),
        .rst_n  (Rst),
        .push   (push),
        .pop    (pop),
        .wr_data(Wr_Data),
        .head   (head),
        .empty  (Queue_Empty),
        .full   (Queue_Full),
        .count  (Count)
    );

    // sticky drop flag; a dropped write in the same cycle as a clear keeps it set
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) Queue_Overflow <= 1'b0;
        else if (Wr_En && !push) Queue_Overflow <= 1'b1;
        else if (Overflow_Clr) Queue_Overflow <= 1'b0;

    // launch FSM: present head, wait for the acknowledge, retry if it never comes
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) begin
            state          <= IDLE;
            tmr            <= '0;
            Tx_Data        <= '0;
            Transmit_Start <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (!Queue_Empty && CTS) begin
                        Tx_Data        <= head;
                        Transmit_Start <= 1'b1;
                        state          <= START;
                    end
                START: begin
                    Transmit_Start <= 1'b0;
                    tmr            <= '0;
                    state          <= WAIT_BUSY;
                end
                WAIT_BUSY:
                    if (Tx_Busy) state <= WAIT_DONE;
                    else if (tmr == TW'(LAUNCH_TIMEOUT - 1)) state <= IDLE;
                    else tmr <= tmr + TW'(1);
                WAIT_DONE:
                    if (!Tx_Busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_tx_queue.sv
// tb_tx_queue: table-driven and scoreboard checks of the transmit queue
module tb_tx_queue;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic          wr;
        logic [DW-1:0] d;
        logic          clr;
        int            cnt;
        logic          full;
        logic          ovf;
        logic          keep;
    } vec_t;

    logic          Clk, Rst, Wr_En, CTS, Overflow_Clr, Tx_Busy;
    logic [DW-1:0] Wr_Data, Tx_Data;
    logic          Transmit_Start, Queue_Empty, Queue_Full, Queue_Overflow;
    logic [CW-1:0] Count;
    logic          man_busy, mdl_busy, auto_tx, mon_en;
    logic          mon_ts_prev, mon_busy_prev;
    logic [DW-1:0] exp_q[$];
    vec_t          vecs[20];
    int            n_checks = 0;
    int            n_fail = 0;
    int            ign_req, ign_done;

    assign Tx_Busy = auto_tx ? mdl_busy : man_busy;

    tx_queue #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Wr_Data       (Wr_Data),
        .Wr_En         (Wr_En),
        .CTS           (CTS),
        .Tx_Busy       (Tx_Busy),
        .Overflow_Clr  (Overflow_Clr),
        .Tx_Data       (Tx_Data),
        .Transmit_Start(Transmit_Start),
        .Queue_Empty   (Queue_Empty),
        .Queue_Full    (Queue_Full),
        .Queue_Overflow(Queue_Overflow),
        .Count         (Count)
    );

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // transmitter model: acknowledge each start one cycle later, busy for three cycles
    initial begin
        mdl_busy = 0;
        ign_done = 0;
        forever begin
            @(negedge Clk);
            if (auto_tx && Transmit_Start) begin
                if (ign_done < ign_req) ign_done++;
                else begin
                    @(posedge Clk);
                    #1 mdl_busy = 1;
                    repeat (3) @(posedge Clk);
                    #1 mdl_busy = 0;
                end
            end
        end
    end

    // scoreboard monitor: every launch must carry the oldest outstanding word
    initial begin
        mon_ts_prev = 0;
        mon_busy_prev = 0;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (Transmit_Start) begin
                    chk("start_pulse_width", int'(mon_ts_prev), 0);
                    chk("launch_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("tx_data", int'(Tx_Data), int'(exp_q[0]));
                end
                if (Tx_Busy && !mon_busy_prev && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            mon_ts_prev = Transmit_Start;
            mon_busy_prev = Tx_Busy;
        end
    end

    initial begin
        int first, second, pulses, cnt_at;
        Rst = 0; Wr_En = 0; Wr_Data = '0; CTS = 0; Overflow_Clr = 0;
        man_busy = 0; auto_tx = 0; mon_en = 0; ign_req = 0;
        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 8'(i), 1'b0, i + 1, (i == 15), 1'b0, 1'b1};
        vecs[16] = '{1'b1, 8'h10, 1'b1, 16, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 8'h11, 1'b0, 16, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0};

        repeat (6) begin
            @(negedge Clk);
            #1;
            Wr_En = 1'($urandom_range(0, 1));
            Wr_Data = 8'($urandom);
            CTS = 1'($urandom_range(0, 1));
            Overflow_Clr = 1'($urandom_range(0, 1));
            man_busy = 1'($urandom_range(0, 1));
        end
        @(negedge Clk);
        chk("rst_tx_data", int'(Tx_Data), 0);
        chk("rst_start", int'(Transmit_Start), 0);
        chk("rst_empty", int'(Queue_Empty), 1);
        chk("rst_full", int'(Queue_Full), 0);
        chk("rst_overflow", int'(Queue_Overflow), 0);
        chk("rst_count", int'(Count), 0);
        #1;
        Wr_En = 0; CTS = 0; Overflow_Clr = 0; man_busy = 0;
        Rst = 1; mon_en = 1;

        @(negedge Clk);
        #1;
        Wr_En = 1; Wr_Data = 8'hA5; CTS = 1; auto_tx = 1;
        exp_q.push_back(8'hA5);
        @(negedge Clk);
        chk("sw_empty_fall", int'(Queue_Empty), 0);
        chk("sw_count_1", int'(Count), 1);
        chk("sw_no_start_yet", int'(Transmit_Start), 0);
        #1 Wr_En = 0;
        @(negedge Clk);
        chk("sw_start", int'(Transmit_Start), 1);
        chk("sw_tx_data", int'(Tx_Data), 'hA5);
        @(negedge Clk);
        chk("sw_start_low", int'(Transmit_Start), 0);
        chk("sw_count_before_pop", int'(Count), 1);
        @(negedge Clk);
        chk("sw_count_after_pop", int'(Count), 0);
        chk("sw_empty_after_pop", int'(Queue_Empty), 1);
        repeat (6) @(negedge Clk);

        for (int i = 0; i < 20; i++) begin
            #1;
            CTS = 0;
            Wr_En = vecs[i].wr;
            Wr_Data = vecs[i].d;
            Overflow_Clr = vecs[i].clr;
            if (vecs[i].keep) exp_q.push_back(vecs[i].d);
            @(negedge Clk);
            chk($sformatf("fill_count[%0d]", i), int'(Count), vecs[i].cnt);
            chk($sformatf("fill_full[%0d]", i), int'(Queue_Full), int'(vecs[i].full));
            chk($sformatf("fill_ovf[%0d]", i), int'(Queue_Overflow), int'(vecs[i].ovf));
            chk($sformatf("fill_empty[%0d]", i), int'(Queue_Empty), int'(vecs[i].cnt == 0));
        end
        #1;
        Wr_En = 0; Overflow_Clr = 0;

        auto_tx = 0; man_busy = 0; CTS = 1;
        @(negedge Clk);
        chk("pf_launch", int'(Transmit_Start), 1);
        @(negedge Clk);
        chk("pf_count_pre", int'(Count), 16);
        #1;
        man_busy = 1; Wr_En = 1; Wr_Data = 8'h20;
        exp_q.push_back(8'h20);
        @(negedge Clk);
        chk("pf_count", int'(Count), 16);
        chk("pf_full", int'(Queue_Full), 1);
        chk("pf_overflow", int'(Queue_Overflow), 0);
        #1;
        Wr_En = 0; man_busy = 0; auto_tx = 1;
        for (int t = 0; t < 600 && exp_q.size() != 0; t++) @(negedge Clk);
        chk("drain_all_words", exp_q.size(), 0);
        repeat (8) @(negedge Clk);
        chk("drain_empty", int'(Queue_Empty), 1);
        chk("drain_count", int'(Count), 0);

        #1;
        ign_req = ign_done + 1;
        Wr_En = 1; Wr_Data = 8'h5A;
        exp_q.push_back(8'h5A);
        first = -1; second = -1; pulses = 0; cnt_at = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge Clk);
            if (Transmit_Start) begin
                pulses++;
                if (first < 0) first = j;
                else if (second < 0) begin
                    second = j;
                    cnt_at = int'(Count);
                end
            end
            if (j == 1) #1 Wr_En = 0;
        end
        chk("to_first_start", first, 2);
        chk("to_retry_start", second, 8);
        chk("to_count_at_retry", cnt_at, 1);
        chk("to_pulses", pulses, 2);
        chk("to_word_consumed", exp_q.size(), 0);

        #1;
        auto_tx = 0; man_busy = 0; CTS = 0;
        for (int i = 0; i < 4; i++) begin
            Wr_En = 1;
            Wr_Data = 8'(8'h31 + i);
            @(negedge Clk);
            #1;
        end
        Wr_En = 0;
        exp_q.push_back(8'h31);
        chk("rm_count_pre", int'(Count), 4);
        CTS = 1;
        @(negedge Clk);
        chk("rm_launch", int'(Transmit_Start), 1);
        @(negedge Clk);
        #1 man_busy = 1;
        @(negedge Clk);
        chk("rm_count_wait_done", int'(Count), 3);
        #1 Rst = 0;
        #1;
        chk("rm_count_async", int'(Count), 0);
        chk("rm_empty_async", int'(Queue_Empty), 1);
        chk("rm_full_async", int'(Queue_Full), 0);
        chk("rm_start_async", int'(Transmit_Start), 0);
        exp_q.delete();
        man_busy = 0;
        @(negedge Clk);
        #1 Rst = 1;
        pulses = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Transmit_Start) pulses++;
        end
        chk("rm_no_launch", pulses, 0);
        chk("rm_empty_after", int'(Queue_Empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
